// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multicycle CPU controller: state encoding, opcodes,
// ALU operand/op selects and the bundle of control lines driven each state.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_LOAD  = 4'd3,
        WB_MEM    = 4'd4,
        MEM_STORE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        WB_ALU    = 4'd8,
        BRANCH    = 4'd9,
        HALT      = 4'd10
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH1 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       pc_source;
        logic       halt;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        pc_write:      1'b0,
        pc_write_cond: 1'b0,
        iord:          1'b0,
        mem_read:      1'b0,
        mem_write:     1'b0,
        ir_write:      1'b0,
        mem_to_reg:    1'b0,
        reg_write:     1'b0,
        alu_src_a:     1'b0,
        pc_source:     1'b0,
        halt:          1'b0,
        alu_src_b:     SRCB_REG,
        alu_op:        ALU_ADD
    };

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: status in, control lines and debug state out.
interface multicycle_controller_if #(parameter int CNT_W = 32);
    import multicycle_controller_pkg::*;

    logic [6:0]       opcode;
    logic             alu_zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic             pc_source;
    logic             halt;
    alu_src_b_t       alu_src_b;
    alu_op_t          alu_op;
    state_t           state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, alu_src_a, pc_source, halt,
               alu_src_b, alu_op, state, retired
    );

    modport slave (
        output opcode, alu_zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, alu_src_a, pc_source, halt,
               alu_src_b, alu_op, state, retired
    );

endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM with a retired-instruction counter. Only ir_write
// and pc_write depend on mem_ready directly; every other output is Moore.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    state_t           state_q;
    state_t           state_d;
    logic             retire;
    logic [CNT_W-1:0] retired_q;
    ctrl_t            ctrl;

    // The datapath qualifies branches with alu_zero, so the controller never reads it.
    logic unused_alu_zero;
    assign unused_alu_zero = bus.alu_zero;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       retired_q <= '0;
        else if (retire) retired_q <= retired_q + CNT_W'(1);
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            FETCH:     if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    OPC_LOAD, OPC_STORE: state_d = MEM_ADDR;
                    OPC_OP:              state_d = EXEC_R;
                    OPC_OP_IMM:          state_d = EXEC_I;
                    OPC_BRANCH:          state_d = BRANCH;
                    default:             state_d = HALT;
                endcase
            end
            MEM_ADDR:  state_d = (bus.opcode == OPC_LOAD) ? MEM_LOAD : MEM_STORE;
            MEM_LOAD:  if (bus.mem_ready) state_d = WB_MEM;
            WB_MEM: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            MEM_STORE: begin
                if (bus.mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXEC_R, EXEC_I: state_d = WB_ALU;
            WB_ALU, BRANCH: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            HALT:      state_d = HALT;
            default:   state_d = FETCH;
        endcase
    end

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state_q)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            DECODE:    ctrl.alu_src_b = SRCB_IMM_SH1;
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEM_LOAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            EXEC_R, EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = (state_q == EXEC_I) ? SRCB_IMM : SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            WB_ALU:    ctrl.reg_write = 1'b1;
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
            end
            HALT:      ctrl.halt = 1'b1;
            default:   ctrl = CTRL_IDLE;
        endcase
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.iord          = ctrl.iord;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.halt          = ctrl.halt;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.state         = state_q;
    assign bus.retired       = retired_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clock port clk, reset port reset.
REQ-002 Parameter: CNT_W, 32, width of the retired-instruction counter.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 opcode  input  7  instruction[6:0] from the instruction register; stable except when ir_write=1.
REQ-006 alu_zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access completes this cycle.
REQ-008 Control outputs: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a, pc_source, halt; each output 1 bit.
REQ-009 alu_src_b  output  2  operand-B select: 00 = B, 01 = constant 4, 10 = imm, 11 = imm<<1.
REQ-010 alu_op  output  2  ALU op class: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
REQ-011 state  output  4  current state encoding, for debug.
REQ-012 retired  output  CNT_W  count of completed instructions.

Function
REQ-013 States: FETCH, DECODE, MEM_ADDR, MEM_LOAD, WB_MEM, MEM_STORE, EXEC_R, EXEC_I, WB_ALU, BRANCH, HALT.
REQ-014 Every control output not listed for a state SHALL be 0 in that state.
REQ-015 FETCH: mem_read=1, iord=0, alu_src_a=0 (old PC), alu_src_b=01, alu_op=00.
- If mem_ready=1: ir_write=1, pc_write=1, pc_source=0, go to DECODE.
- Otherwise: hold in FETCH with ir_write=0 and pc_write=0 (combinational on mem_ready).
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
- 0000011 or 0100011 -> MEM_ADDR
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 1100011 -> BRANCH
- any other opcode -> HALT
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; go to MEM_LOAD if opcode=0000011, else MEM_STORE.
REQ-018 MEM_LOAD: mem_read=1, iord=1; hold until mem_ready=1, then go to WB_MEM.
REQ-019 WB_MEM: reg_write=1, mem_to_reg=1; go to FETCH.
REQ-020 MEM_STORE: mem_write=1, iord=1; hold until mem_ready=1, then go to FETCH.
REQ-021 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; go to WB_ALU. EXEC_I: same except alu_src_b=10.
REQ-022 WB_ALU: reg_write=1, mem_to_reg=0; go to FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1; go to FETCH. The datapath gates PC load with alu_zero; the controller does not branch on alu_zero.
REQ-024 HALT: halt=1, all other controls 0; remain in HALT until reset.
REQ-025 Latency with mem_ready held 1: R/I-type 4 cycles, load 5, store 4, branch 3. Each wait cycle in FETCH, MEM_LOAD or MEM_STORE adds exactly 1 cycle.
REQ-026 retired SHALL increment by 1 on the clock edge leaving each of these:
- WB_MEM, WB_ALU, BRANCH
- MEM_STORE when mem_ready=1
REQ-027 retired SHALL wrap from 2^CNT_W-1 to 0 without any flag. HALT does not count.
REQ-028 All outputs except ir_write and pc_write SHALL be Moore (state only).

Reset
REQ-029 Asserting reset SHALL immediately force state=FETCH, retired=0 and halt=0, including mid-access. Outputs then take FETCH values with mem_read=1.
REQ-030 After reset deasserts, the first rising edge SHALL evaluate FETCH normally.

Structure
REQ-031 Shared package SHALL hold:
- the state enum (4-bit)
- the opcode constants (LOAD, STORE, OP, OP_IMM, BRANCH)
- the alu_src_b and alu_op encodings
REQ-032 The block SHALL be a single module with no sub-module: a registered state plus counter and a combinational output/next-state decode.

Verification
REQ-033 Reset, opcode=0110011, mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_ALU; reg_write=1 only in cycle 4; retired=1 after cycle 4.
REQ-034 Load, mem_ready=0 for 3 cycles in MEM_LOAD -> mem_read=1 and iord=1 held 4 cycles; instruction takes 8 cycles; reg_write=1, mem_to_reg=1 in the last cycle.
REQ-035 opcode=1100011 -> BRANCH in cycle 3 with pc_write_cond=1, pc_source=1, alu_op=01; FETCH in cycle 4; retired +1.
REQ-036 opcode=1111111 -> HALT after DECODE; halt=1 for 10 further cycles; retired unchanged; reset returns to FETCH.
REQ-037 Reset asserted between clock edges in MEM_STORE -> mem_write falls without waiting for clk; state=FETCH, retired=0.
REQ-038 CNT_W=4, 16 back-to-back R-type instructions -> retired=0 after the 16th; 17th -> retired=1.
